// File: rtl/alu_pkg.sv
// alu_pkg: shared types and widths for the ALU arbiter slice.
//   alu_op_e    - 3-bit ALU opcodes (ADD..PASS_A)
//   arb_state_e - arbiter FSM states (IDLE, EXEC, RESP)
//   ALU_W/FLAG_W - ALU data and flag widths
package alu_pkg;

  localparam int ALU_W  = 8;
  localparam int FLAG_W = 4;

  typedef enum logic [2:0] {
    ADD    = 3'b000,
    SUB    = 3'b001,
    SHL    = 3'b010,
    SHR    = 3'b011,
    AND    = 3'b100,
    OR     = 3'b101,
    NOT    = 3'b110,
    PASS_A = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational grant selection for the ALU arbiter.
//   req   - request vector
//   ptr   - round-robin start index (first candidate considered)
//   grant - one-hot grant (zero when no request)
//   idx   - binary index of the granted requester
//   any   - at least one request present
// Build option: ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
        any      = 1'b1;
      end
    end
  end
`else
  // Two passes: first the requesters at or above ptr, then wrap to the bottom.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i] && (IW'(i) >= ptr)) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
        any      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
        any      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between N_REQ requesters, one op in flight.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester request handshake (ready one-hot in IDLE)
//   req_op/req_a/req_b  - packed per-requester opcode and operands
//   rsp_valid/rsp_ready - per-requester response handshake (valid one-hot in RESP)
//   rsp_result/carry/flag - shared response data, valid for the owner only
//   alu_op/alu_a/alu_b  - registered ALU operand port
//   alu_result/carry/flag - ALU outputs, ALU_LAT register stages after the operands
//   busy                - high whenever the FSM is not IDLE
// Build option: ALU_ARB_FIXED_PRIO_EN -> fixed lowest-index priority, no rr_ptr.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [3*N_REQ-1:0]   req_op,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [ALU_W-1:0]     rsp_result,
  output logic                 rsp_carry,
  output logic [FLAG_W-1:0]    rsp_flag,
  output logic [2:0]           alu_op,
  output logic [ALU_W-1:0]     alu_a,
  output logic [ALU_W-1:0]     alu_b,
  input  logic [ALU_W-1:0]     alu_result,
  input  logic                 alu_carry,
  input  logic [FLAG_W-1:0]    alu_flag,
  output logic                 busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_grant;
  logic [N_REQ-1:0] owner_oh;
  logic             win_any;
  logic             rsp_hs;
  logic [2:0]       cnt;
  logic [2:0]       sel_op;
  logic [ALU_W-1:0] sel_a;
  logic [ALU_W-1:0] sel_b;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    sel_op   = PASS_A;
    sel_a    = '0;
    sel_b    = '0;
    owner_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_grant[i]) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[8*i +: 8];
        sel_b  = req_b[8*i +: 8];
      end
      if (owner == IW'(i)) owner_oh[i] = 1'b1;
    end
  end

  assign req_ready = (state == IDLE) ? win_grant : '0;
  assign rsp_valid = (state == RESP) ? owner_oh : '0;
  assign rsp_hs    = |(rsp_valid & rsp_ready);
  assign busy      = (state != IDLE);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (rsp_hs) begin
      rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      cnt        <= '0;
      alu_op     <= PASS_A;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_flag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            alu_op <= sel_op;
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            owner  <= win_idx;
            cnt    <= 3'(ALU_LAT);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_flag   <= alu_flag;
            state      <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized checks of alu_arbiter against a
// behavioural model. Three DUT copies share clk/rst_n with ALU_LAT = 1, 0, 3,
// each wrapped by a bench ALU with the matching number of register stages.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid  [NI];
  logic [1:0] req_ready  [NI];
  logic [5:0] req_op     [NI];
  logic [15:0] req_a     [NI];
  logic [15:0] req_b     [NI];
  logic [1:0] rsp_valid  [NI];
  logic [1:0] rsp_ready  [NI];
  logic [7:0] rsp_result [NI];
  logic       rsp_carry  [NI];
  logic [3:0] rsp_flag   [NI];
  logic [2:0] alu_op     [NI];
  logic [7:0] alu_a      [NI];
  logic [7:0] alu_b      [NI];
  logic [7:0] alu_result [NI];
  logic       alu_carry  [NI];
  logic [3:0] alu_flag   [NI];
  logic       busy       [NI];

  int checks   = 0;
  int failures = 0;
  int ptr_m [NI];
  logic [7:0] last_res;
  logic [1:0] last_grant;

  always #5 clk = ~clk;

  // Bench ALU: flag = {zero, negative, carry, parity}.
  function automatic logic [12:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] t;
    logic       c;
    logic [7:0] r;
    c = 1'b0;
    r = a;
    t = '0;
    case (op)
      3'b000: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
      3'b001: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; end
      3'b010: begin r = {a[6:0], 1'b0}; c = a[7]; end
      3'b011: begin r = {1'b0, a[7:1]}; c = a[0]; end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = ~a;
      default: r = a;
    endcase
    return {c, (r == 8'd0), r[7], c, ^r, r};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [12:0] pipe [8];

    alu_arbiter #(.N_REQ(N), .ALU_LAT(L)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_result (rsp_result[g]),
      .rsp_carry  (rsp_carry[g]),
      .rsp_flag   (rsp_flag[g]),
      .alu_op     (alu_op[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_result (alu_result[g]),
      .alu_carry  (alu_carry[g]),
      .alu_flag   (alu_flag[g]),
      .busy       (busy[g])
    );

    always @(posedge clk) begin
      pipe[0] <= alu_model(alu_op[g], alu_a[g], alu_b[g]);
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    if (L == 0) begin : comb_alu
      assign {alu_carry[g], alu_flag[g], alu_result[g]} = alu_model(alu_op[g], alu_a[g], alu_b[g]);
    end else begin : reg_alu
      assign {alu_carry[g], alu_flag[g], alu_result[g]} = pipe[L-1];
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // Reference: integer arithmetic straight from the opcode table.
  function automatic logic [12:0] ref_calc(input int op, input int a, input int b);
    int r, c, ones;
    c = 0;
    ones = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: begin r = (a * 2) % 256; c = a / 128; end
      3: begin r = a / 2; c = a % 2; end
      4: r = a & b;
      5: r = a | b;
      6: r = 255 - a;
      default: r = a;
    endcase
    for (int t = r; t > 0; t = t / 2) ones += t % 2;
    return {c[0], (r == 0), (r >= 128), c[0], ones[0], r[7:0]};
  endfunction

  function automatic int exp_winner(input int k, input logic [1:0] v);
    int p;
`ifdef ALU_ARB_FIXED_PRIO_EN
    p = 0;
`else
    p = ptr_m[k];
`endif
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input int i, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_op[k][3*i +: 3] = op;
    req_a[k][8*i +: 8]  = a;
    req_b[k][8*i +: 8]  = b;
  endtask

  // Called and returns at a negedge. One full request/response transaction.
  task automatic txn(input int k, input logic [1:0] vmask, input int hold,
                     input bit keep_valid, input bit early_rdy);
    int w, e;
    logic [12:0] ex;
    req_valid[k] = vmask;
    #1;
    w = exp_winner(k, vmask);
    last_grant = req_ready[k];
    chk("req_ready_grant", req_ready[k], 1 << w);
    chk("busy_idle", busy[k], 0);
    ex = ref_calc(req_op[k][3*w +: 3], req_a[k][8*w +: 8], req_b[k][8*w +: 8]);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) req_valid[k][w] = 1'b0;
    if (early_rdy) rsp_ready[k] = 2'(1 << w);
    e = 0;
    while (rsp_valid[k] == 2'b00 && e < 20) begin
      chk("busy_exec", busy[k], 1);
      chk("req_ready_exec", req_ready[k], 0);
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    chk("rsp_latency", e, lat_of(k) + 1);
    chk("rsp_valid_owner", rsp_valid[k], 1 << w);
    chk("rsp_result", rsp_result[k], ex[7:0]);
    chk("rsp_carry", rsp_carry[k], ex[12]);
    chk("rsp_flag", rsp_flag[k], ex[11:8]);
    last_res = rsp_result[k];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", rsp_valid[k], 1 << w);
      chk("hold_result", rsp_result[k], ex[7:0]);
      chk("hold_req_ready", req_ready[k], 0);
      chk("hold_busy", busy[k], 1);
    end
    rsp_ready[k] = 2'(1 << w);
    @(posedge clk);
    @(negedge clk);
    ptr_m[k] = (w + 1) % N;
    chk("rsp_valid_cleared", rsp_valid[k], 0);
    chk("busy_after_hs", busy[k], 0);
    rsp_ready[k] = 2'b00;
    if (!keep_valid) req_valid[k] = 2'b00;
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_alu_op", alu_op[k], 3'b111);
    chk("rst_alu_a", alu_a[k], 0);
    chk("rst_alu_b", alu_b[k], 0);
    chk("rst_rsp_valid", rsp_valid[k], 0);
    chk("rst_req_ready", req_ready[k], 0);
    chk("rst_busy", busy[k], 0);
    chk("rst_rsp_result", rsp_result[k], 0);
    chk("rst_rsp_carry", rsp_carry[k], 0);
    chk("rst_rsp_flag", rsp_flag[k], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] vm;
    int k, hold;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = '0; rsp_ready[i] = '0;
      req_op[i] = '0; req_a[i] = '0; req_b[i] = '0;
      ptr_m[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk_reset_vals(i);
    rst_n = 1'b1;
    @(negedge clk);

    // Req0 ADD, rsp_ready already high.
    set_req(0, 0, 3'b000, 8'h2A, 8'h9F);
    txn(0, 2'b01, 0, 1'b0, 1'b1);
    chk("t1_add_result", last_res, 8'hC9);

    // Req1 NOT, response back-pressured 5 cycles; rr_ptr wraps 1 -> 0.
    set_req(0, 1, 3'b110, 8'h2A, 8'h9F);
    txn(0, 2'b10, 5, 1'b0, 1'b0);
    chk("t4_not_result", last_res, 8'hD5);

    // Req0 AND and Req1 OR together: order 0 then 1.
    set_req(0, 0, 3'b100, 8'h2A, 8'h9F);
    set_req(0, 1, 3'b101, 8'h2A, 8'h9F);
    txn(0, 2'b11, 0, 1'b0, 1'b1);
    chk("t2_first_grant", last_grant, 2'b01);
    chk("t2_and_result", last_res, 8'h0A);
    txn(0, 2'b10, 0, 1'b0, 1'b1);
    chk("t2_second_grant", last_grant, 2'b10);
    chk("t2_or_result", last_res, 8'hBF);

    // Valid withdrawn before any clock edge: no accept, operands untouched.
    req_valid[0] = 2'b01;
    #1;
    chk("drop_ready_seen", req_ready[0], 2'b01);
    req_valid[0] = 2'b00;
    #1;
    chk("drop_ready_gone", req_ready[0], 0);
    @(posedge clk);
    @(negedge clk);
    chk("drop_busy", busy[0], 0);
    chk("drop_alu_op_held", alu_op[0], 3'b101);
    chk("drop_alu_a_held", alu_a[0], 8'h2A);

    // Both continuously valid, six ops back to back.
    set_req(0, 0, 3'b000, 8'h11, 8'h22);
    set_req(0, 1, 3'b001, 8'h10, 8'h20);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] eg;
`ifdef ALU_ARB_FIXED_PRIO_EN
      eg = 2'b01;
`else
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      txn(0, 2'b11, 0, 1'b1, 1'b1);
      chk("t3_grant_seq", last_grant, eg);
    end
    req_valid[0] = 2'b00;

    // Leave rr_ptr at 1, then reset in the middle of a SHL.
    txn(0, 2'b01, 0, 1'b0, 1'b1);
    set_req(0, 0, 3'b010, 8'h2A, 8'h9F);
    req_valid[0] = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 2'b00;
    rsp_ready[0] = 2'b01;
    chk("t5_busy_exec", busy[0], 1);
    chk("t5_alu_a_latched", alu_a[0], 8'h2A);
    rst_n = 1'b0;
    #1;
    chk_reset_vals(0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) ptr_m[i] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid[0], 0);
      chk("t5_idle", busy[0], 0);
    end
    rsp_ready[0] = 2'b00;
    set_req(0, 0, 3'b111, 8'h5A, 8'h00);
    txn(0, 2'b11, 0, 1'b0, 1'b1);
    chk("t5_ptr_reset_grant", last_grant, 2'b01);

    // PASS_A then SHR on the zero- and three-stage ALU copies.
    for (int kk = 1; kk < NI; kk++) begin
      set_req(kk, 0, 3'b111, 8'h2A, 8'h9F);
      txn(kk, 2'b01, 0, 1'b0, 1'b1);
      chk("t6_pass_result", last_res, 8'h2A);
      set_req(kk, 1, 3'b011, 8'h2A, 8'h9F);
      txn(kk, 2'b10, 1, 1'b0, 1'b0);
      chk("t6_shr_result", last_res, 8'h15);
    end

    // Randomized transactions across all three copies.
    for (int it = 0; it < 24; it++) begin
      k = $urandom_range(0, NI - 1);
      for (int r = 0; r < N; r++)
        set_req(k, r, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      vm = 2'($urandom_range(1, 3));
      hold = $urandom_range(0, 3);
      txn(k, vm, hold, 1'b0, (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
